// File: rtl/echo_path_emulator.sv
// Far-end echo channel model: local talker plus a 4-tap FIR echo of the sent
// signal after a bulk delay, computed once per sample period.
module echo_path_emulator #(
  parameter int unsigned        DELAY      = 0,
  parameter logic signed [15:0] COEF0_INIT = 16'sh4000,
  parameter logic signed [15:0] COEF1_INIT = 16'sh0000,
  parameter logic signed [15:0] COEF2_INIT = 16'sh0000,
  parameter logic signed [15:0] COEF3_INIT = 16'sh0000
) (
  input  logic               clk_operation,
  input  logic               rst,
  input  logic               enable,
  input  logic [12:0]        sampling_cycle_counter,
  input  logic signed [15:0] sig16b,
  input  logic signed [15:0] sig16b_local,
  input  logic               coef_wr,
  input  logic [1:0]         coef_addr,
  input  logic signed [15:0] coef_data,
  output logic signed [15:0] sig16b_lag,
  output logic               valid,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned DEPTH = DELAY + 4;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_MAC, S_OUTPUT} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_cnt0_d;
  logic [AW-1:0]      r_wptr;
  logic [1:0]         r_tap;
  logic signed [35:0] r_acc;
  logic signed [15:0] r_lag;
  logic               r_valid;
  logic               r_overrun;
  logic signed [15:0] r_buf  [DEPTH];
  logic signed [15:0] r_live [4];
  logic signed [15:0] r_work [4];

  logic               w_cnt0;
  logic               w_strobe;
  logic [AW:0]        w_idx_sum;
  logic [AW-1:0]      w_rd_idx;
  logic [AW-1:0]      w_wptr_nxt;
  logic signed [31:0] w_prod;
  logic signed [35:0] w_rnd;
  logic signed [35:0] w_shift;
  logic signed [15:0] w_sat;

  assign w_cnt0   = (sampling_cycle_counter == '0);
  assign w_strobe = w_cnt0 & ~r_cnt0_d;

  // DEPTH - DELAY == 4, so (wptr - DELAY - k) mod DEPTH == wptr + (4 - k), wrapped at most once.
  assign w_idx_sum  = (AW+1)'(r_wptr) + (AW+1)'(3'd4 - {1'b0, r_tap});
  assign w_rd_idx   = (w_idx_sum >= (AW+1)'(DEPTH)) ? AW'(w_idx_sum - (AW+1)'(DEPTH))
                                                     : AW'(w_idx_sum);
  assign w_wptr_nxt = (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;

  assign w_prod  = 32'(r_work[r_tap]) * 32'(r_buf[w_rd_idx]);
  assign w_rnd   = r_acc + 36'sd16384;
  assign w_shift = w_rnd >>> 15;

  always_comb begin
    w_sat = w_shift[15:0];
    if (w_shift > 36'sd32767)
      w_sat = 16'sh7FFF;
    else if (w_shift < -36'sd32768)
      w_sat = 16'sh8000;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:    if (w_strobe && enable) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_MAC;
      S_MAC:     if (r_tap == 2'd3) w_state_nxt = S_OUTPUT;
      S_OUTPUT:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt0_d  <= 1'b0;
      r_wptr    <= '0;
      r_tap     <= '0;
      r_acc     <= '0;
      r_lag     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_live[0] <= COEF0_INIT;
      r_live[1] <= COEF1_INIT;
      r_live[2] <= COEF2_INIT;
      r_live[3] <= COEF3_INIT;
      for (int unsigned i = 0; i < 4; i++) r_work[i] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt0_d <= w_cnt0;
      r_valid  <= 1'b0;
      if (coef_wr)
        r_live[coef_addr] <= coef_data;
      if (w_strobe && (r_state != S_IDLE))
        r_overrun <= 1'b1;
      case (r_state)
        S_CAPTURE: begin
          // Snapshot sees the pre-write live bank when coef_wr coincides.
          r_buf[r_wptr] <= sig16b;
          r_work        <= r_live;
          r_acc         <= {{5{sig16b_local[15]}}, sig16b_local, 15'd0};
          r_tap         <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + {{4{w_prod[31]}}, w_prod};
          r_tap <= r_tap + 2'd1;
        end
        S_OUTPUT: begin
          r_lag   <= w_sat;
          r_valid <= 1'b1;
          r_wptr  <= w_wptr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign sig16b_lag = r_lag;
  assign valid      = r_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_echo_path_emulator.sv
// Directed bench for echo_path_emulator (DELAY=0 and DELAY=4 instances) with a
// sample-level reference model compared every cycle.
module tb_echo_path_emulator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b1;
  logic [12:0]        cnt = 13'd1;
  logic signed [15:0] x = '0;
  logic signed [15:0] l = '0;
  logic               coef_wr = 1'b0;
  logic [1:0]         caddr = '0;
  logic signed [15:0] cdata = '0;

  logic signed [15:0] lag0, lag4;
  logic               valid0, valid4, busy0, busy4, ovr0, ovr4;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int s_cyc = 0;

  always #5 clk = ~clk;

  echo_path_emulator #(.DELAY(0)) u_dut0 (
    .clk_operation(clk), .rst(rst), .enable(enable), .sampling_cycle_counter(cnt),
    .sig16b(x), .sig16b_local(l), .coef_wr(coef_wr), .coef_addr(caddr), .coef_data(cdata),
    .sig16b_lag(lag0), .valid(valid0), .busy(busy0), .overrun(ovr0));

  echo_path_emulator #(.DELAY(4)) u_dut4 (
    .clk_operation(clk), .rst(rst), .enable(enable), .sampling_cycle_counter(cnt),
    .sig16b(x), .sig16b_local(l), .coef_wr(coef_wr), .coef_addr(caddr), .coef_data(cdata),
    .sig16b_lag(lag4), .valid(valid4), .busy(busy4), .overrun(ovr4));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
  endtask

  // Reference model: per-instance sample history and a phase counter 0..6 after the strobe.
  int m_t[2], m_lag[2], m_l[2], m_n[2];
  bit m_pz[2], m_val[2], m_ovr[2];
  int m_live[4];
  int m_snap[2][4];
  int m_hist[2][256];

  function automatic int out_sample(input longint acc);
    longint y;
    y = (acc + 64'sd16384) >>> 15;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return int'(y);
  endfunction

  task automatic model_step(input int d);
    bit z, stb;
    int dl, idx;
    longint acc;
    dl  = (d == 0) ? 0 : 4;
    z   = (cnt == 13'd0);
    stb = z && !m_pz[d];
    m_pz[d]  = z;
    m_val[d] = 1'b0;
    if (m_t[d] == 0) begin
      if (stb && enable) m_t[d] = 1;
    end else begin
      if (stb) m_ovr[d] = 1'b1;
      if (m_t[d] == 1) begin
        m_hist[d][m_n[d]] = x;
        m_n[d]++;
        for (int k = 0; k < 4; k++) m_snap[d][k] = m_live[k];
        m_l[d] = l;
        m_t[d] = 2;
      end else if (m_t[d] < 6) begin
        m_t[d]++;
      end else begin
        acc = longint'(m_l[d]) * 64'sd32768;
        for (int k = 0; k < 4; k++) begin
          idx = m_n[d] - 1 - dl - k;
          if (idx >= 0) acc += longint'(m_snap[d][k]) * longint'(m_hist[d][idx]);
        end
        m_lag[d] = out_sample(acc);
        m_val[d] = 1'b1;
        m_t[d]   = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_t[d] = 0; m_pz[d] = 1'b0; m_lag[d] = 0; m_val[d] = 1'b0; m_ovr[d] = 1'b0; m_n[d] = 0;
      end
      m_live[0] = 16384; m_live[1] = 0; m_live[2] = 0; m_live[3] = 0;
    end else begin
      model_step(0);
      model_step(1);
      if (coef_wr) m_live[caddr] = cdata;
    end
    #1;
    chk("valid0", int'(valid0), int'(m_val[0]));
    chk("valid4", int'(valid4), int'(m_val[1]));
    chk("lag0", int'(lag0), m_lag[0]);
    chk("lag4", int'(lag4), m_lag[1]);
    chk("busy0", int'(busy0), int'(m_t[0] != 0));
    chk("busy4", int'(busy4), int'(m_t[1] != 0));
    chk("ovr0", int'(ovr0), int'(m_ovr[0]));
    chk("ovr4", int'(ovr4), int'(m_ovr[1]));
  end

  task automatic wcoef(input logic [1:0] a, input logic signed [15:0] v);
    @(negedge clk); coef_wr = 1'b1; caddr = a; cdata = v;
    @(negedge clk); coef_wr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the negedge just after strobe edge S; s_cyc holds S.
  task automatic strobe_begin(input logic signed [15:0] xv, input logic signed [15:0] lv);
    @(negedge clk); x = xv; l = lv; cnt = 13'd0;
    @(posedge clk); #1; s_cyc = cyc;
    @(negedge clk); cnt = 13'd1;
  endtask

  task automatic wait_out(input string nm, input bit c0, input int e0, input bit c4, input int e4);
    int guard = 0;
    while (cyc < s_cyc + 6 && guard < 12) begin
      @(posedge clk); #1; guard++;
      if (cyc == s_cyc + 5) chk({nm, "_early_valid"}, int'(valid0), 0);
    end
    chk({nm, "_valid0"}, int'(valid0), 1);
    chk({nm, "_valid4"}, int'(valid4), 1);
    if (c0) chk({nm, "_lag0"}, int'(lag0), e0);
    if (c4) chk({nm, "_lag4"}, int'(lag4), e4);
  endtask

  task automatic count_valid(input string nm, input int n);
    int nv = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (valid0 || valid4) nv++;
    end
    chk(nm, nv, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tx[4];
    int ty[4];
    tx = '{1000, 2000, 3000, -3};
    ty = '{500, 1000, 1500, -1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_lag0", int'(lag0), 0);
    chk("rst_lag4", int'(lag4), 0);
    chk("rst_valid0", int'(valid0), 0);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_ovr0", int'(ovr0), 0);

    // Pass-through with all taps zero.
    for (int k = 0; k < 4; k++) wcoef(2'(k), 16'sh0000);
    strobe_begin(-16'sd5000, 16'sd1234);
    wait_out("pass", 1'b1, 1234, 1'b1, 1234);

    // Single tap, DELAY=0 instance, including the -1.5 rounding case.
    wcoef(2'd0, 16'sh4000);
    for (int i = 0; i < 4; i++) begin
      strobe_begin(16'(tx[i]), 16'sd0);
      wait_out("tap0", 1'b1, ty[i], 1'b0, 0);
    end

    // Saturation both ways.
    wcoef(2'd0, 16'sh7FFF);
    strobe_begin(16'sh7FFF, 16'sh7FFF);
    wait_out("sat_pos", 1'b1, 32767, 1'b0, 0);
    strobe_begin(16'sh8000, 16'sh8000);
    wait_out("sat_neg", 1'b1, -32768, 1'b0, 0);

    // Impulse through 4 equal taps; DELAY=4 buffer wraps several times.
    do_reset();
    for (int k = 0; k < 4; k++) wcoef(2'(k), 16'sh2000);
    for (int i = 0; i < 20; i++) begin
      strobe_begin((i == 0) ? 16'sd16384 : 16'sd0, 16'sd0);
      wait_out("impulse", 1'b1, (i < 4) ? 4096 : 0, 1'b1, (i >= 4 && i < 8) ? 4096 : 0);
    end

    // Coefficient write during MAC only affects the next sample.
    do_reset();
    strobe_begin(16'sd1000, 16'sd0);
    @(negedge clk);
    @(negedge clk); coef_wr = 1'b1; caddr = 2'd0; cdata = 16'sh2000;
    @(negedge clk); coef_wr = 1'b0;
    wait_out("mac_wr_a", 1'b1, 500, 1'b1, 0);
    strobe_begin(16'sd1000, 16'sd0);
    wait_out("mac_wr_b", 1'b1, 250, 1'b1, 0);

    // Write coinciding with CAPTURE: snapshot keeps the old value.
    strobe_begin(16'sd2000, 16'sd0);
    coef_wr = 1'b1; caddr = 2'd0; cdata = 16'sh4000;
    @(negedge clk); coef_wr = 1'b0;
    wait_out("cap_wr_a", 1'b1, 500, 1'b0, 0);
    strobe_begin(16'sd2000, 16'sd0);
    wait_out("cap_wr_b", 1'b1, 1000, 1'b0, 0);

    // Second strobe three cycles into a sample.
    strobe_begin(16'sd1000, 16'sd0);
    @(negedge clk);
    @(negedge clk); cnt = 13'd0;
    @(negedge clk); cnt = 13'd1;
    wait_out("ovr", 1'b1, 500, 1'b0, 0);
    chk("ovr_set0", int'(ovr0), 1);
    chk("ovr_set4", int'(ovr4), 1);

    // Disabled strobe is ignored.
    enable = 1'b0;
    strobe_begin(16'sd5000, 16'sd0);
    count_valid("dis_novalid", 8);
    enable = 1'b1;
    chk("ovr_sticky", int'(ovr0), 1);

    // Enable dropping mid-sample does not abort it.
    strobe_begin(16'sd3000, 16'sd0);
    @(negedge clk); enable = 1'b0;
    wait_out("en_drop", 1'b1, 1500, 1'b0, 0);
    enable = 1'b1;

    // Reset at S+3 aborts; next sample uses cleared history and default taps.
    wcoef(2'd0, 16'sh1000);
    strobe_begin(16'sd2000, 16'sd0);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    count_valid("rst_novalid", 8);
    chk("rstmid_lag0", int'(lag0), 0);
    chk("rstmid_lag4", int'(lag4), 0);
    chk("rstmid_ovr0", int'(ovr0), 0);
    strobe_begin(16'sd1000, 16'sd0);
    wait_out("post_rst", 1'b1, 500, 1'b1, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
